vga_pattern_gen: RTL and testbench
==================================

// Module: vga_pattern_gen
// PURPOSE
//  Pixel-colour stage directly downstream of the VGA sync/timing generator.
//  Consumes the timing outputs: h_sync, v_sync and the active-video window.
//  Tracks pixel x/y internally and produces 1-bit R/G/B for four test patterns.
//  Re-times h_sync/v_sync so that colour and sync leave the block aligned.
// PARAMETERS
//  H_ACTIVE     640  active pixels per line
//  V_ACTIVE     480  active lines per frame
//  CLK_PER_PIX  2    clk cycles per pixel (50 MHz clk, 25 MHz pixel)
//  BAR_WIDTH    80   colour-bar width in pixels (H_ACTIVE/8)
//  CHECK_SHIFT  5    checkerboard square = 2**CHECK_SHIFT pixels
//  BOX_SIZE     32   bouncing-box edge length in pixels
// PORTS
//  clk        in   1   system clock
//  reset      in   1   asynchronous, active-high reset
//  h_sync     in   1   horizontal sync from timing stage, active-low
//  v_sync     in   1   vertical sync from timing stage, active-low
//  de         in   1   active-video window (high = visible pixel time)
//  mode       in   2   0 bars, 1 checker, 2 bouncing box, 3 solid
//  solid_rgb  in   3   {r,g,b} colour used in mode 3
//  vga_red    out  1   red to DAC/pin
//  vga_green  out  1   green to DAC/pin
//  vga_blue   out  1   blue to DAC/pin
//  h_sync_o   out  1   h_sync delayed to match colour
//  v_sync_o   out  1   v_sync delayed to match colour
// BEHAVIOUR
//  - Reset (async, active-high): rgb=000, h_sync_o=1, v_sync_o=1.
//    Also x=0, y=0, phase=0, box (0,0), dx=+1, dy=+1, mode_q=0, solid_q=000.
//  - Fixed latency 2 clk: the outputs at cycle n+2 reflect the inputs at cycle n,
//    including rgb, h_sync_o and v_sync_o.
//  - Stage 1 registers h_sync, v_sync and de into *_d1.
//  - Stage 2 registers the outputs.
//  - Frame start (fs) = v_sync_d1 high and v_sync low, i.e. a falling edge.
//  - Line end (le) = de_d1 high and de low.
//  - Pixel phase: counts 0..CLK_PER_PIX-1 while de_d1=1. When the phase wraps,
//    x increments, saturating at H_ACTIVE-1. When de_d1=0, x=0 and phase=0.
//  - y increments on le, saturating at V_ACTIVE-1. y clears on fs.
//    If fs and le occur in the same cycle, fs wins and y=0.
//  - On fs:
//    - Latch mode into mode_q and solid_rgb into solid_q.
//      The pattern never changes mid-frame.
//    - Advance the box by one pixel per frame.
//    - If bx+dx is below 0 or above H_ACTIVE-BOX_SIZE, negate dx and do not
//      move bx that frame. by/dy use the same rule with V_ACTIVE.
//    - Box corners are therefore reached exactly, with no overshoot.
//  - Colour (computed from x, y, mode_q), {r,g,b}:
//    - mode 0: bar=x/BAR_WIDTH (0..7); rgb=~bar[2:0]. Bar 0 is white, bar 7 black.
//    - mode 1: rgb = (x[CHECK_SHIFT]^y[CHECK_SHIFT]) ? 111 : 000.
//    - mode 2: inside box -> 100 (red), else 001 (blue).
//      Inside box means bx<=x<bx+BOX_SIZE and by<=y<by+BOX_SIZE.
//    - mode 3: rgb = solid_q.
//  - Blanking: rgb is forced to 000 whenever the delayed de is 0.
//  - No division in hardware:
//    - mode 0 uses a bar counter that increments every BAR_WIDTH pixels and
//      clears with x.
//    - Box compare is 10-bit unsigned.
//  - Reset mid-frame: the first frame is garbage until the next fs; y counts
//    from 0. Outputs must never be X.
// TESTING
//  - Reset held with random inputs -> rgb=000, h_sync_o=v_sync_o=1 throughout.
//  - Toggle h_sync/v_sync/de in isolation -> each output edge appears exactly
//    2 clk later; rgb=000 whenever de is low.
//  - mode=0, one 1280-clk de line -> 8 bars of 160 clk each.
//    Colours in order: 111,110,101,100,011,010,001,000.
//  - mode=1 -> rgb toggles every 64 clk within a line; the phase inverts
//    between lines 31 and 32.
//  - mode=2, run 609 frames:
//    - bx reaches 608, holds one frame, then decreases.
//    - Box pixels are red at x in [bx, bx+31]; everything else is blue.
//  - Change mode from 0 to 3 mid-frame with solid_rgb=010:
//    - The current frame stays as bars.
//    - The next frame is all 010 in active video.

Source files
------------

// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if: timing-in / pixel-out bundle for the VGA test-pattern stage.
// Latency: n/a (wires only).
// Backpressure: none; the video stream is free-running.
// Signals: h_sync, v_sync (active-low), de, mode[1:0], solid_rgb[2:0] toward the
//          pattern stage; vga_red/green/blue, h_sync_o, v_sync_o back from it.
interface vga_pattern_gen_if;
   logic       h_sync;
   logic       v_sync;
   logic       de;
   logic [1:0] mode;
   logic [2:0] solid_rgb;
   logic       vga_red;
   logic       vga_green;
   logic       vga_blue;
   logic       h_sync_o;
   logic       v_sync_o;

   // master: the timing source / board side; slave: the pattern generator
   modport master (
      output h_sync, v_sync, de, mode, solid_rgb,
      input  vga_red, vga_green, vga_blue, h_sync_o, v_sync_o
   );

   modport slave (
      input  h_sync, v_sync, de, mode, solid_rgb,
      output vga_red, vga_green, vga_blue, h_sync_o, v_sync_o
   );
endinterface

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: 1-bit RGB test patterns (bars, checker, bouncing box, solid) behind the VGA timing stage.
// Latency: fixed 2 clk from h_sync/v_sync/de inputs to rgb and re-timed h_sync_o/v_sync_o.
// Backpressure: none; one input sample consumed and one output produced every clk.
// Ports: clk, reset (async, active-high); bus (slave): h_sync, v_sync, de, mode, solid_rgb in;
//        vga_red, vga_green, vga_blue, h_sync_o, v_sync_o out.
module vga_pattern_gen #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int CLK_PER_PIX = 2,
   parameter int BAR_WIDTH   = 80,
   parameter int CHECK_SHIFT = 5,
   parameter int BOX_SIZE    = 32
) (
   input  logic             clk,
   input  logic             reset,
   vga_pattern_gen_if.slave bus
);
   localparam int XW  = 10;
   localparam int YW  = 10;
   localparam int PW  = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;
   localparam int BPW = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;

   // stage 1: delayed timing
   logic           h_sync_d1_q, h_sync_d1_d;
   logic           v_sync_d1_q, v_sync_d1_d;
   logic           de_d1_q, de_d1_d;
   // pixel position
   logic [PW-1:0]  phase_q, phase_d;
   logic [XW-1:0]  x_q, x_d;
   logic [YW-1:0]  y_q, y_d;
   logic [BPW-1:0] bar_px_q, bar_px_d;
   logic [2:0]     bar_q, bar_d;
   // per-frame state
   logic [XW-1:0]  bx_q, bx_d;
   logic [YW-1:0]  by_q, by_d;
   logic           dx_neg_q, dx_neg_d;
   logic           dy_neg_q, dy_neg_d;
   logic [1:0]     mode_q, mode_d;
   logic [2:0]     solid_q, solid_d;
   // stage 2: outputs
   logic [2:0]     rgb_q, rgb_d;
   logic           h_sync_o_q, h_sync_o_d;
   logic           v_sync_o_q, v_sync_o_d;

   logic           fs;
   logic           le;
   logic           box_hit;
   logic [2:0]     pix;

   always_comb begin
      h_sync_d1_d = bus.h_sync;
      v_sync_d1_d = bus.v_sync;
      de_d1_d     = bus.de;
      phase_d     = '0;
      x_d         = '0;
      bar_px_d    = '0;
      bar_d       = '0;
      y_d         = y_q;
      bx_d        = bx_q;
      by_d        = by_q;
      dx_neg_d    = dx_neg_q;
      dy_neg_d    = dy_neg_q;
      mode_d      = mode_q;
      solid_d     = solid_q;
      pix         = 3'b000;

      // Edges are taken between the stage-1 copy and the live input, so the
      // state change lands exactly on the first pixel of the new frame/line.
      fs = v_sync_d1_q & ~bus.v_sync;
      le = de_d1_q & ~bus.de;

      // x and the bar counter clear whenever the delayed window is closed.
      if (de_d1_q) begin
         phase_d  = phase_q;
         x_d      = x_q;
         bar_px_d = bar_px_q;
         bar_d    = bar_q;
         if (phase_q == PW'(CLK_PER_PIX - 1)) begin
            phase_d = '0;
            if (x_q != XW'(H_ACTIVE - 1)) begin
               x_d = x_q + XW'(1);
               // bar index tracks x/BAR_WIDTH without a divider
               if (bar_px_q == BPW'(BAR_WIDTH - 1)) begin
                  bar_px_d = '0;
                  if (bar_q != 3'd7) begin
                     bar_d = bar_q + 3'd1;
                  end
               end else begin
                  bar_px_d = bar_px_q + BPW'(1);
               end
            end
         end else begin
            phase_d = phase_q + PW'(1);
         end
      end

      // frame start takes priority over a coincident line end
      if (fs) begin
         y_d = '0;
      end else if (le && (y_q != YW'(V_ACTIVE - 1))) begin
         y_d = y_q + YW'(1);
      end

      if (fs) begin
         mode_d  = bus.mode;
         solid_d = bus.solid_rgb;
         // At an edge the direction flips and the box holds for one frame,
         // so it parks exactly on the limit instead of overshooting.
         if (dx_neg_q) begin
            if (bx_q == '0) dx_neg_d = 1'b0;
            else            bx_d     = bx_q - XW'(1);
         end else begin
            if (bx_q >= XW'(H_ACTIVE - BOX_SIZE)) dx_neg_d = 1'b1;
            else                                  bx_d     = bx_q + XW'(1);
         end
         if (dy_neg_q) begin
            if (by_q == '0) dy_neg_d = 1'b0;
            else            by_d     = by_q - YW'(1);
         end else begin
            if (by_q >= YW'(V_ACTIVE - BOX_SIZE)) dy_neg_d = 1'b1;
            else                                  by_d     = by_q + YW'(1);
         end
      end

      box_hit = (x_q >= bx_q) && (x_q < (bx_q + XW'(BOX_SIZE))) &&
                (y_q >= by_q) && (y_q < (by_q + YW'(BOX_SIZE)));

      case (mode_q)
         2'd0:    pix = ~bar_q;
         2'd1:    pix = {3{x_q[CHECK_SHIFT] ^ y_q[CHECK_SHIFT]}};
         2'd2:    pix = box_hit ? 3'b100 : 3'b001;
         default: pix = solid_q;
      endcase

      rgb_d      = de_d1_q ? pix : 3'b000;
      h_sync_o_d = h_sync_d1_q;
      v_sync_o_d = v_sync_d1_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_sync_d1_q <= 1'b1;
         v_sync_d1_q <= 1'b1;
         de_d1_q     <= 1'b0;
         phase_q     <= '0;
         x_q         <= '0;
         y_q         <= '0;
         bar_px_q    <= '0;
         bar_q       <= '0;
         bx_q        <= '0;
         by_q        <= '0;
         dx_neg_q    <= 1'b0;
         dy_neg_q    <= 1'b0;
         mode_q      <= 2'd0;
         solid_q     <= 3'b000;
         rgb_q       <= 3'b000;
         h_sync_o_q  <= 1'b1;
         v_sync_o_q  <= 1'b1;
      end else begin
         h_sync_d1_q <= h_sync_d1_d;
         v_sync_d1_q <= v_sync_d1_d;
         de_d1_q     <= de_d1_d;
         phase_q     <= phase_d;
         x_q         <= x_d;
         y_q         <= y_d;
         bar_px_q    <= bar_px_d;
         bar_q       <= bar_d;
         bx_q        <= bx_d;
         by_q        <= by_d;
         dx_neg_q    <= dx_neg_d;
         dy_neg_q    <= dy_neg_d;
         mode_q      <= mode_d;
         solid_q     <= solid_d;
         rgb_q       <= rgb_d;
         h_sync_o_q  <= h_sync_o_d;
         v_sync_o_q  <= v_sync_o_d;
      end
   end

   assign bus.vga_red   = rgb_q[2];
   assign bus.vga_green = rgb_q[1];
   assign bus.vga_blue  = rgb_q[0];
   assign bus.h_sync_o  = h_sync_o_q;
   assign bus.v_sync_o  = v_sync_o_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: self-checking bench for the VGA test-pattern stage.
// Latency: expects every output 2 clk after the input it reflects.
// Backpressure: none; inputs are driven every clk.
module tb_vga_pattern_gen;
   localparam int H_ACTIVE  = 640;
   localparam int V_ACTIVE  = 480;
   localparam int BAR_WIDTH = 80;
   localparam int BOX_SIZE  = 32;
   localparam int LINE_CLK  = 1280;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   vga_pattern_gen_if bus ();

   vga_pattern_gen dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [2:0] rgb;
      logic       hs;
      logic       vs;
   } out_t;

   typedef struct {
      bit   h;
      bit   v;
      bit   de;
      out_t exp;
   } vec_t;

   int         checks   = 0;
   int         failures = 0;
   int         cyc      = 0;
   out_t       exp_q[$];
   out_t       last_out;
   logic [2:0] line_rgb [LINE_CLK];
   vec_t       tbl [12];

   // reference model: position from counted de cycles / de falling edges
   bit         m_prev_v;
   bit         m_prev_de;
   int         m_run;
   int         m_y;
   int         m_mode;
   bit [2:0]   m_solid;
   int         m_bx, m_by, m_dx, m_dy;

   function automatic out_t read_out();
      return {bus.vga_red, bus.vga_green, bus.vga_blue, bus.h_sync_o, bus.v_sync_o};
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic void model_reset();
      m_prev_v  = 1'b1;
      m_prev_de = 1'b0;
      m_run     = 0;
      m_y       = 0;
      m_mode    = 0;
      m_solid   = 3'b000;
      m_bx      = 0;
      m_by      = 0;
      m_dx      = 1;
      m_dy      = 1;
      exp_q.delete();
      exp_q.push_back(out_t'(5'b000_1_1));
   endfunction

   function automatic logic [2:0] model_colour(input int x, input int y);
      case (m_mode)
         0: return 3'(7 - x / BAR_WIDTH);
         1: return (((x >> 5) & 1) != ((y >> 5) & 1)) ? 3'b111 : 3'b000;
         2: return (x >= m_bx && x < m_bx + BOX_SIZE && y >= m_by && y < m_by + BOX_SIZE)
                   ? 3'b100 : 3'b001;
         default: return m_solid;
      endcase
   endfunction

   function automatic void model_push(input bit h, input bit v, input bit de,
                                      input int mode, input bit [2:0] solid);
      bit         fs, le;
      int         x;
      logic [2:0] col;
      fs = m_prev_v && !v;
      le = m_prev_de && !de;
      if (fs) begin
         m_y     = 0;
         m_mode  = mode;
         m_solid = solid;
         if (m_bx + m_dx < 0 || m_bx + m_dx > H_ACTIVE - BOX_SIZE) m_dx = -m_dx;
         else                                                      m_bx = m_bx + m_dx;
         if (m_by + m_dy < 0 || m_by + m_dy > V_ACTIVE - BOX_SIZE) m_dy = -m_dy;
         else                                                      m_by = m_by + m_dy;
      end else if (le && m_y < V_ACTIVE - 1) begin
         m_y = m_y + 1;
      end
      if (de) begin
         x = m_run / 2;
         if (x > H_ACTIVE - 1) x = H_ACTIVE - 1;
         col   = model_colour(x, m_y);
         m_run = m_run + 1;
      end else begin
         m_run = 0;
         col   = 3'b000;
      end
      exp_q.push_back({col, h, v});
      m_prev_v  = v;
      m_prev_de = de;
   endfunction

   // one clk: drive inputs, advance model, compare output against the model
   task automatic step(input bit h, input bit v, input bit de,
                       input int mode, input bit [2:0] solid);
      out_t e;
      bus.h_sync    = h;
      bus.v_sync    = v;
      bus.de        = de;
      bus.mode      = 2'(mode);
      bus.solid_rgb = solid;
      model_push(h, v, de, mode, solid);
      @(posedge clk);
      #1;
      cyc++;
      e        = exp_q.pop_front();
      last_out = read_out();
      checks++;
      if (last_out !== e) begin
         failures++;
         $display("FAIL stream cyc=%0d: got rgb=%b hs=%b vs=%b, required rgb=%b hs=%b vs=%b",
                  cyc, last_out.rgb, last_out.hs, last_out.vs, e.rgb, e.hs, e.vs);
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      #1;
      check("reset_async", int'(read_out()), 5'b000_1_1);
      for (int i = 0; i < n; i++) begin
         bus.h_sync    = 1'($urandom);
         bus.v_sync    = 1'($urandom);
         bus.de        = 1'($urandom);
         bus.mode      = 2'($urandom);
         bus.solid_rgb = 3'($urandom);
         @(posedge clk);
         #1;
         check("reset_hold", int'(read_out()), 5'b000_1_1);
      end
      reset = 1'b0;
      model_reset();
   endtask

   task automatic frame_start(input int mode, input bit [2:0] solid);
      step(1'b1, 1'b0, 1'b0, mode, solid);
      step(1'b1, 1'b1, 1'b0, mode, solid);
   endtask

   task automatic short_lines(input int n, input int mode, input bit [2:0] solid);
      for (int i = 0; i < n; i++) begin
         step(1'b1, 1'b1, 1'b1, mode, solid);
         step(1'b1, 1'b1, 1'b0, mode, solid);
      end
   endtask

   // full 1280-clk active line; line_rgb[i] is the colour of clk i of the line
   task automatic scan_line(input int mode_a, input int mode_b, input int sw,
                            input bit [2:0] solid);
      for (int i = 0; i < LINE_CLK; i++) begin
         step(1'b1, 1'b1, 1'b1, (i < sw) ? mode_a : mode_b, solid);
         if (i > 0) line_rgb[i-1] = last_out.rgb;
      end
      step(1'b1, 1'b1, 1'b0, mode_b, solid);
      line_rgb[LINE_CLK-1] = last_out.rgb;
   endtask

   task automatic box_scan(input int bx, input string tag);
      int         first, last, bad, last_req;
      logic [2:0] want;
      first = -1;
      last  = -1;
      bad   = 0;
      scan_line(2, 2, 0, 3'b000);
      for (int p = 0; p < H_ACTIVE; p++) begin
         want = (p >= bx && p <= bx + BOX_SIZE - 1) ? 3'b100 : 3'b001;
         for (int ph = 0; ph < 2; ph++) begin
            if (line_rgb[2*p+ph] !== want) bad++;
         end
         if (line_rgb[2*p] == 3'b100) begin
            if (first < 0) first = p;
            last = p;
         end
      end
      last_req = (bx + BOX_SIZE - 1 > H_ACTIVE - 1) ? H_ACTIVE - 1 : bx + BOX_SIZE - 1;
      check({tag, "_first_red"}, first, bx);
      check({tag, "_last_red"}, last, last_req);
      check({tag, "_bad_pixels"}, bad, 0);
   endtask

   initial begin
      int         bad;
      int         mr, len, blank;
      bit [2:0]   sr;

      bus.h_sync    = 1'b1;
      bus.v_sync    = 1'b1;
      bus.de        = 1'b0;
      bus.mode      = 2'd0;
      bus.solid_rgb = 3'b000;
      #2;
      do_reset(4);

      // isolated sync/de toggles: {h, v, de} -> output seen after this clk
      tbl[0]  = '{1'b1, 1'b1, 1'b0, out_t'(5'b000_1_1)};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, out_t'(5'b000_1_1)};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, out_t'(5'b000_0_1)};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, out_t'(5'b000_1_1)};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, out_t'(5'b000_1_0)};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, out_t'(5'b000_1_1)};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, out_t'(5'b111_1_1)};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, out_t'(5'b111_1_1)};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, out_t'(5'b000_1_1)};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, out_t'(5'b000_1_1)};
      tbl[10] = '{1'b1, 1'b1, 1'b0, out_t'(5'b111_0_0)};
      tbl[11] = '{1'b1, 1'b1, 1'b0, out_t'(5'b000_1_1)};
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].h, tbl[i].v, tbl[i].de, 0, 3'b000);
         check($sformatf("vec%0d", i), int'(last_out), int'(tbl[i].exp));
      end

      // colour bars: 8 bars of 160 clk, white down to black
      frame_start(0, 3'b000);
      scan_line(0, 0, 0, 3'b000);
      for (int b = 0; b < 8; b++) begin
         check($sformatf("bar%0d_first", b), line_rgb[160*b], 7 - b);
         check($sformatf("bar%0d_last", b), line_rgb[160*b+159], 7 - b);
      end

      // mode switched to solid mid-frame: bars persist until next frame start
      scan_line(0, 3, 640, 3'b010);
      check("midframe_x0", line_rgb[0], 3'b111);
      check("midframe_x350", line_rgb[700], 3'b011);
      check("midframe_x639", line_rgb[LINE_CLK-1], 3'b000);
      frame_start(3, 3'b010);
      scan_line(3, 3, 0, 3'b010);
      bad = 0;
      for (int i = 0; i < LINE_CLK; i++) if (line_rgb[i] !== 3'b010) bad++;
      check("solid_next_frame_bad", bad, 0);

      // checkerboard: 64-clk squares, phase flips between lines 31 and 32
      frame_start(1, 3'b000);
      short_lines(31, 1, 3'b000);
      scan_line(1, 1, 0, 3'b000);
      for (int k = 0; k < 20; k++) begin
         check($sformatf("chk_y31_sq%0d_first", k), line_rgb[64*k], (k % 2) ? 7 : 0);
         check($sformatf("chk_y31_sq%0d_last", k), line_rgb[64*k+63], (k % 2) ? 7 : 0);
      end
      scan_line(1, 1, 0, 3'b000);
      for (int k = 0; k < 20; k++) begin
         check($sformatf("chk_y32_sq%0d_first", k), line_rgb[64*k], (k % 2) ? 0 : 7);
         check($sformatf("chk_y32_sq%0d_last", k), line_rgb[64*k+63], (k % 2) ? 0 : 7);
      end

      // bouncing box from a mid-frame reset: right edge at 608, hold, return
      do_reset(3);
      for (int f = 0; f < 608; f++) frame_start(2, 3'b000);
      short_lines(m_by, 2, 3'b000);
      box_scan(608, "box_f608");
      frame_start(2, 3'b000);
      short_lines(m_by, 2, 3'b000);
      box_scan(608, "box_f609");
      frame_start(2, 3'b000);
      short_lines(m_by, 2, 3'b000);
      box_scan(607, "box_f610");

      // randomized segments against the model
      for (int seg = 0; seg < 150; seg++) begin
         int kind;
         kind = $urandom_range(0, 9);
         mr   = $urandom_range(0, 3);
         sr   = 3'($urandom);
         if (seg == 60) begin
            // long run of lines so y reaches its saturation point
            frame_start(mr, sr);
            short_lines(490, mr, sr);
            scan_line(mr, mr, 0, sr);
         end else if (kind <= 1) begin
            len = $urandom_range(1, 3);
            for (int i = 0; i < len; i++) step(1'($urandom), 1'b0, 1'b0, mr, sr);
            step(1'b1, 1'b1, 1'b0, mr, sr);
         end else if (kind <= 4) begin
            len   = $urandom_range(1, 1400);
            blank = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) step(1'b1, 1'b1, 1'b1, mr, sr);
            for (int i = 0; i < blank; i++) step(i != 1, 1'b1, 1'b0, mr, sr);
         end else if (kind <= 6) begin
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
               blank = $urandom_range(1, 4);
               for (int j = 0; j < blank; j++) step(1'b1, 1'b1, 1'b1, mr, sr);
               step(1'b1, 1'b1, 1'b0, mr, sr);
            end
         end else if (kind <= 8) begin
            for (int i = 0; i < 40; i++)
               step(1'($urandom), $urandom_range(0, 3) != 0, 1'($urandom),
                    $urandom_range(0, 3), 3'($urandom));
         end else begin
            do_reset($urandom_range(1, 4));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
